prince_sbox_cms_sched: RTL and testbench
========================================

# prince_sbox_cms_sched

Nibble-serial scheduler that shares one first-order CMS-masked PRINCE Sbox core between all 16 nibbles of a 64-bit, two-share PRINCE state. It accepts a masked state, issues one nibble per cycle into the external, non-stallable Sbox pipeline, and collects the returned nibbles. It presents the substituted state on a valid/ready output port. It sits between the PRINCE round datapath and the Sbox core built from the per-bit share functions and their compression layer.

## Interface
- `SBOX_LAT`, default 2: pipeline depth of the attached Sbox core in cycles, from `sb_in_*` to `sb_out_*`. Legal range is 1..4.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: a masked state is offered.
- `in_ready` output, 1 bit: the scheduler can accept a state.
- `in_sh0` input, 64 bits: state share 0.
- `in_sh1` input, 64 bits: state share 1.
- `sb_in_valid` output, 1 bit: a nibble is being issued to the Sbox core.
- `sb_in_sh0` output, 4 bits: Sbox input nibble, share 0.
- `sb_in_sh1` output, 4 bits: Sbox input nibble, share 1.
- `sb_out_sh0` input, 4 bits: Sbox output nibble, share 0. Valid `SBOX_LAT` cycles after issue.
- `sb_out_sh1` input, 4 bits: Sbox output nibble, share 1.
- `out_valid` output, 1 bit: the substituted state is available.
- `out_ready` input, 1 bit: the consumer accepts the state.
- `out_sh0` output, 64 bits: result share 0.
- `out_sh1` output, 64 bits: result share 1.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- FSM states are IDLE, FEED, DRAIN and DONE, plus CLEAR when `SCHED_ZEROIZE_EN` is defined.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` the block loads `in_sh0` and `in_sh1` into the state registers, sets the issue counter to 0 and goes to FEED.
- **FEED**
  - `sb_in_valid` = 1.
  - `sb_in_shX` = state share X, bits [4i+3:4i], where i is the issue counter. Nibble 0 (the LSB) goes first.
  - The issue counter increments every cycle. After i = 15 the FSM goes to DRAIN.
- **Valid tracking**
  - A shift register `SBOX_LAT` bits deep carries `sb_in_valid`.
  - When its tail is 1, the block writes `sb_out_sh0`/`sb_out_sh1` into result nibble c and increments the collect counter c.
  - The write happens in FEED and in DRAIN.
- **DRAIN**
  - `sb_in_valid` = 0.
  - The FSM goes to DONE in the cycle that collects nibble 15.
- **DONE**
  - `out_valid` = 1, and `out_sh*` holds the full result.
  - On `out_ready` the FSM returns to IDLE, or to CLEAR if `SCHED_ZEROIZE_EN` is defined.
- **Shares**
  - Shares are never combined.
  - The two shares of a nibble are always issued in the same cycle and written back in the same cycle.
- **Sbox core**
  - The core has no backpressure, so the scheduler never pauses mid-pass.
- **Input while busy**
  - `in_valid` outside IDLE is ignored, because `in_ready` = 0.

## Timing
- Cycle 0 is the accept edge, where `in_valid` and `in_ready` are both 1.
- Cycles 1..16: `sb_in_valid` = 1, and nibble k is issued in cycle 1+k.
- Nibble k is captured at the end of cycle 1+k+`SBOX_LAT`.
- `out_valid` rises in cycle 17+`SBOX_LAT`. With `SBOX_LAT` = 2 that is cycle 19.
- `out_valid` is held until `out_ready`, with stable data while held.
- `in_ready` returns to 1 in the cycle after the output handshake, or 2 cycles after it with zeroization.
- Throughput is at most one state per 18+`SBOX_LAT` cycles.
- All outputs are registered, except `in_ready`, `out_valid` and `busy`, which are decoded from the state register.
- **Reset values**
  - State is IDLE.
  - `in_ready` = 1.
  - `busy`, `out_valid` and `sb_in_valid` = 0.
  - `sb_in_sh*` = 0 and `out_sh*` = 0.
  - Counters = 0.
  - The valid shift register is cleared to zero.
- **Reset mid-pass**: nibbles still inside the Sbox pipeline are discarded. They are never written, because the valid shift register is cleared.
- **`out_ready` already high when DONE is entered**: the handshake completes in the first DONE cycle.

## Configuration
- `SCHED_ZEROIZE_EN` defined:
  - After the output handshake the FSM spends one CLEAR cycle.
  - In that cycle both share registers of the state and the result are written to zero, and `sb_in_sh*` is zeroed.
  - `busy` = 1 and `in_ready` = 0 during CLEAR. The FSM then goes to IDLE.
- Not defined:
  - The FSM goes directly from DONE to IDLE.
  - Registers retain the last values.
  - `sb_in_sh*` holds nibble 15.

## Test plan
- **Basic pass**: `SBOX_LAT` = 2, `in_sh0` = 0x0123456789ABCDEF, `in_sh1` = 0, ideal Sbox model -> `out_valid` in cycle 19, `out_sh0`^`out_sh1` = S applied nibble-wise (0xBF32AC916780E5D4 for S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4).
- **Masked input**: random `in_sh1`, and `in_sh0` = plain ^ `in_sh1` -> unmasked result equals the Sbox model. `sb_in_sh0`/`sb_in_sh1` match the input nibble shares in order 0..15.
- **Backpressure**: hold `out_ready` = 0 for 10 cycles -> `out_valid` and `out_sh*` stay stable, `in_ready` = 0, and a new `in_valid` is ignored.
- **Reset mid-pass**: assert `rst` in cycle 9 -> the next cycle shows IDLE with all outputs at reset values. A subsequent pass completes correctly with no stale nibbles.
- **Back-to-back**: two states with `in_valid` held high -> second acceptance in cycle 20 (cycle 21 with `SCHED_ZEROIZE_EN`). Both results are correct.
- **Latency sweep**: `SBOX_LAT` = 1 and 4 -> `out_valid` in cycles 18 and 21. With `SCHED_ZEROIZE_EN`, all registers read 0 after CLEAR.

Source files
------------

// File: rtl/prince_sbox_cms_sched.sv
// Nibble-serial scheduler sharing one two-share CMS PRINCE Sbox core across 16 nibbles; SCHED_ZEROIZE_EN adds a CLEAR wipe cycle.
// Latency: accept -> out_valid after 17+SBOX_LAT cycles; one nibble issued per cycle, Sbox pipeline never stalled.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, no pause mid-pass.
module prince_sbox_cms_sched #(
    parameter int SBOX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_sh0,
    input  logic [63:0] in_sh1,
    output logic        sb_in_valid,
    output logic [3:0]  sb_in_sh0,
    output logic [3:0]  sb_in_sh1,
    input  logic [3:0]  sb_out_sh0,
    input  logic [3:0]  sb_out_sh1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sh0,
    output logic [63:0] out_sh1,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FEED  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SCHED_ZEROIZE_EN
    localparam logic [2:0] S_CLEAR = 3'd4;
`endif

    logic [2:0]          state;
    logic [63:0]         st_sh0;
    logic [63:0]         st_sh1;
    logic [3:0]          issue_cnt;
    logic [3:0]          coll_cnt;
    logic [SBOX_LAT-1:0] vsr;
    logic [3:0]          issue_nxt;
    logic                collect;

    assign issue_nxt = issue_cnt + 4'd1;
    // The tail of vsr marks the cycle when the nibble issued SBOX_LAT cycles ago appears at sb_out.
    assign collect   = vsr[SBOX_LAT-1] && ((state == S_FEED) || (state == S_DRAIN));
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            st_sh0      <= '0;
            st_sh1      <= '0;
            issue_cnt   <= '0;
            coll_cnt    <= '0;
            vsr         <= '0;
            sb_in_valid <= 1'b0;
            sb_in_sh0   <= '0;
            sb_in_sh1   <= '0;
            out_sh0     <= '0;
            out_sh1     <= '0;
        end else begin
            vsr[0] <= sb_in_valid;
            for (int j = 1; j < SBOX_LAT; j++) begin
                vsr[j] <= vsr[j-1];
            end

            // Both shares of a nibble are written in the same cycle; they are never combined.
            if (collect) begin
                out_sh0[{coll_cnt, 2'b00} +: 4] <= sb_out_sh0;
                out_sh1[{coll_cnt, 2'b00} +: 4] <= sb_out_sh1;
                coll_cnt                        <= coll_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        st_sh0      <= in_sh0;
                        st_sh1      <= in_sh1;
                        issue_cnt   <= '0;
                        coll_cnt    <= '0;
                        sb_in_valid <= 1'b1;
                        sb_in_sh0   <= in_sh0[3:0];
                        sb_in_sh1   <= in_sh1[3:0];
                        state       <= S_FEED;
                    end
                end
                S_FEED: begin
                    issue_cnt <= issue_nxt;
                    if (issue_cnt == 4'd15) begin
                        sb_in_valid <= 1'b0;
                        state       <= S_DRAIN;
                    end else begin
                        sb_in_sh0 <= st_sh0[{issue_nxt, 2'b00} +: 4];
                        sb_in_sh1 <= st_sh1[{issue_nxt, 2'b00} +: 4];
                    end
                end
                S_DRAIN: begin
                    if (collect && (coll_cnt == 4'd15)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
`ifdef SCHED_ZEROIZE_EN
                        state <= S_CLEAR;
`else
                        state <= S_IDLE;
`endif
                    end
                end
`ifdef SCHED_ZEROIZE_EN
                S_CLEAR: begin
                    st_sh0    <= '0;
                    st_sh1    <= '0;
                    out_sh0   <= '0;
                    out_sh1   <= '0;
                    sb_in_sh0 <= '0;
                    sb_in_sh1 <= '0;
                    state     <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prince_sbox_cms_sched.sv
// Self-checking bench: three schedulers (SBOX_LAT 1, 2, 4), each with an ideal masked Sbox pipeline model.
module tb_prince_sbox_cms_sched;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid    [N];
    logic        in_ready    [N];
    logic [63:0] in_sh0      [N];
    logic [63:0] in_sh1      [N];
    logic        sb_in_valid [N];
    logic [3:0]  sb_in_sh0   [N];
    logic [3:0]  sb_in_sh1   [N];
    logic        out_valid   [N];
    logic        out_ready   [N];
    logic [63:0] out_sh0     [N];
    logic [63:0] out_sh1     [N];
    logic        busy        [N];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
            4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
            4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
        endcase
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 16; k++) y[4*k +: 4] = sbox(x[4*k +: 4]);
        return y;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Ideal Sbox: share 1 passes through as the output mask, share 0 carries S(x)^mask; garbage when idle.
    for (genvar g = 0; g < N; g++) begin : gi
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [7:0] pipe [L];
        always @(posedge clk) begin
            if (sb_in_valid[g])
                pipe[0] <= {sbox(sb_in_sh0[g] ^ sb_in_sh1[g]) ^ sb_in_sh1[g], sb_in_sh1[g]};
            else
                pipe[0] <= 8'($urandom());
            for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
        end
        prince_sbox_cms_sched #(.SBOX_LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_sh0     (in_sh0[g]),
            .in_sh1     (in_sh1[g]),
            .sb_in_valid(sb_in_valid[g]),
            .sb_in_sh0  (sb_in_sh0[g]),
            .sb_in_sh1  (sb_in_sh1[g]),
            .sb_out_sh0 (pipe[L-1][7:4]),
            .sb_out_sh1 (pipe[L-1][3:0]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_sh0    (out_sh0[g]),
            .out_sh1    (out_sh1[g]),
            .busy       (busy[g])
        );
    end

    // Drives one pass and reports observations; returns just after the output handshake edge.
    task automatic run_pass(input int g, input logic [63:0] s0, input logic [63:0] s1, input int hold,
                            input bit drive_more, input logic [63:0] n0, input logic [63:0] n1,
                            output int acc, output int ov, output logic [63:0] r0, output logic [63:0] r1,
                            output logic [63:0] i0, output logic [63:0] i1, output int vc, output bit stable);
        int n;
        logic [63:0] h0, h1;
        acc = -1; ov = -1; r0 = '0; r1 = '0; i0 = '0; i1 = '0; vc = 0; stable = 1'b1;
        h0 = '0; h1 = '0;
        @(negedge clk);
        in_sh0[g] = s0; in_sh1[g] = s1; in_valid[g] = 1'b1; out_ready[g] = (hold == 0);
        for (int t = 0; t < 100; t++) begin
            if (in_ready[g]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) return;
        @(negedge clk);
        if (drive_more) begin
            in_sh0[g] = n0; in_sh1[g] = n1;
        end else begin
            in_valid[g] = 1'b0;
        end
        for (int t = 0; t < 200; t++) begin
            n = cyc - acc;
            if (sb_in_valid[g]) begin
                vc++;
                if (n >= 1 && n <= 16) begin
                    i0[4*(n-1) +: 4] = sb_in_sh0[g];
                    i1[4*(n-1) +: 4] = sb_in_sh1[g];
                end
            end
            if (out_valid[g]) begin
                if (ov < 0) begin
                    ov = n; h0 = out_sh0[g]; h1 = out_sh1[g];
                end else if (out_sh0[g] !== h0 || out_sh1[g] !== h1) begin
                    stable = 1'b0;
                end
                if (in_ready[g] !== 1'b0) stable = 1'b0;
                if (n >= ov + hold) out_ready[g] = 1'b1;
                if (out_ready[g]) begin
                    r0 = out_sh0[g]; r1 = out_sh1[g];
                    @(posedge clk);
                    return;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < N; g++) begin
            checks++;
            if ({in_ready[g], busy[g], out_valid[g], sb_in_valid[g], sb_in_sh0[g], sb_in_sh1[g]} !== 12'h800) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %h expected 800", g,
                         {in_ready[g], busy[g], out_valid[g], sb_in_valid[g], sb_in_sh0[g], sb_in_sh1[g]});
            end
            checks++;
            if (out_sh0[g] !== 64'h0 || out_sh1[g] !== 64'h0) begin
                errors++;
                $display("FAIL reset_out[%0d]: got %h/%h expected 0/0", g, out_sh0[g], out_sh1[g]);
            end
        end
    endtask

    task automatic test_basic();
        int acc, ov, vc; bit st;
        logic [63:0] r0, r1, i0, i1, s0;
        s0 = 64'h0123456789ABCDEF;
        run_pass(1, s0, 64'h0, 0, 1'b0, 64'h0, 64'h0, acc, ov, r0, r1, i0, i1, vc, st);
        checks++; if (acc < 0) begin errors++; $display("FAIL basic_accept: got timeout expected accept"); end
        checks++; if (ov !== 19) begin errors++; $display("FAIL basic_latency: got %0d expected 19", ov); end
        checks++; if ((r0 ^ r1) !== 64'hBF32AC916780E5D4) begin
            errors++; $display("FAIL basic_result: got %h expected bf32ac916780e5d4", r0 ^ r1);
        end
        checks++; if (r1 !== 64'h0) begin errors++; $display("FAIL basic_sh1: got %h expected 0", r1); end
        checks++; if (i0 !== s0 || i1 !== 64'h0) begin
            errors++; $display("FAIL basic_issue: got %h/%h expected %h/0", i0, i1, s0);
        end
        checks++; if (vc !== 16) begin errors++; $display("FAIL basic_vld_cnt: got %0d expected 16", vc); end
    endtask

    task automatic test_masked();
        int acc, ov, vc; bit st;
        logic [63:0] r0, r1, i0, i1, p, m;
        for (int k = 0; k < 4; k++) begin
            p = rnd64(); m = rnd64();
            run_pass(1, p ^ m, m, 0, 1'b0, 64'h0, 64'h0, acc, ov, r0, r1, i0, i1, vc, st);
            checks++; if (ov !== 19) begin errors++; $display("FAIL masked_latency: got %0d expected 19", ov); end
            checks++; if ((r0 ^ r1) !== sbox64(p)) begin
                errors++; $display("FAIL masked_result: got %h expected %h", r0 ^ r1, sbox64(p));
            end
            checks++; if (r1 !== m) begin errors++; $display("FAIL masked_sh1: got %h expected %h", r1, m); end
            checks++; if (i0 !== (p ^ m) || i1 !== m) begin
                errors++; $display("FAIL masked_issue: got %h/%h expected %h/%h", i0, i1, p ^ m, m);
            end
            checks++; if (vc !== 16) begin errors++; $display("FAIL masked_vld_cnt: got %0d expected 16", vc); end
        end
    endtask

    task automatic test_backpressure();
        int acc, ov, vc; bit st;
        logic [63:0] r0, r1, i0, i1, p, m;
        p = rnd64(); m = rnd64();
        run_pass(1, p ^ m, m, 10, 1'b1, rnd64(), rnd64(), acc, ov, r0, r1, i0, i1, vc, st);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        checks++; if (ov !== 19) begin errors++; $display("FAIL bp_latency: got %0d expected 19", ov); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %0d expected 1", st); end
        checks++; if ((r0 ^ r1) !== sbox64(p) || r1 !== m) begin
            errors++; $display("FAIL bp_result: got %h/%h expected %h/%h", r0, r1, sbox64(p) ^ m, m);
        end
        checks++; if (busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_ignored: got busy=%0d in_ready=%0d expected 0/1", busy[1], in_ready[1]);
        end
`ifdef SCHED_ZEROIZE_EN
        checks++; if (out_sh0[1] !== 64'h0 || out_sh1[1] !== 64'h0) begin
            errors++; $display("FAIL bp_zeroized: got %h/%h expected 0/0", out_sh0[1], out_sh1[1]);
        end
`else
        checks++; if (out_sh0[1] !== r0 || out_sh1[1] !== r1) begin
            errors++; $display("FAIL bp_retained: got %h/%h expected %h/%h", out_sh0[1], out_sh1[1], r0, r1);
        end
`endif
    endtask

    task automatic test_reset_midpass();
        int acc, ov, vc; bit st;
        logic [63:0] r0, r1, i0, i1, p, m;
        @(negedge clk);
        in_sh0[1] = rnd64(); in_sh1[1] = rnd64(); in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        acc = -1;
        for (int t = 0; t < 50; t++) begin
            if (in_ready[1]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (acc < 0) begin
            errors++; $display("FAIL midpass_accept: got timeout expected accept");
        end else begin
            @(negedge clk);
            in_valid[1] = 1'b0;
            while (cyc - acc < 9) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if ({in_ready[1], busy[1], out_valid[1], sb_in_valid[1], sb_in_sh0[1], sb_in_sh1[1]} !== 12'h800) begin
                errors++;
                $display("FAIL midpass_ctrl: got %h expected 800",
                         {in_ready[1], busy[1], out_valid[1], sb_in_valid[1], sb_in_sh0[1], sb_in_sh1[1]});
            end
            checks++; if (out_sh0[1] !== 64'h0 || out_sh1[1] !== 64'h0) begin
                errors++; $display("FAIL midpass_out: got %h/%h expected 0/0", out_sh0[1], out_sh1[1]);
            end
        end
        p = rnd64(); m = rnd64();
        run_pass(1, p ^ m, m, 0, 1'b0, 64'h0, 64'h0, acc, ov, r0, r1, i0, i1, vc, st);
        checks++; if (ov !== 19 || (r0 ^ r1) !== sbox64(p) || r1 !== m) begin
            errors++; $display("FAIL midpass_next: got lat=%0d %h/%h expected lat=19 %h/%h", ov, r0, r1, sbox64(p) ^ m, m);
        end
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, ov, vc, gap; bit st;
        logic [63:0] ra0, ra1, rb0, rb1, i0, i1, pa, ma, pb, mb;
        pa = rnd64(); ma = rnd64(); pb = rnd64(); mb = rnd64();
`ifdef SCHED_ZEROIZE_EN
        gap = 21;
`else
        gap = 20;
`endif
        run_pass(1, pa ^ ma, ma, 0, 1'b1, pb ^ mb, mb, acc_a, ov, ra0, ra1, i0, i1, vc, st);
        run_pass(1, pb ^ mb, mb, 0, 1'b0, 64'h0, 64'h0, acc_b, ov, rb0, rb1, i0, i1, vc, st);
        checks++; if (acc_b - acc_a !== gap) begin
            errors++; $display("FAIL b2b_gap: got %0d expected %0d", acc_b - acc_a, gap);
        end
        checks++; if ((ra0 ^ ra1) !== sbox64(pa) || ra1 !== ma) begin
            errors++; $display("FAIL b2b_first: got %h/%h expected %h/%h", ra0, ra1, sbox64(pa) ^ ma, ma);
        end
        checks++; if ((rb0 ^ rb1) !== sbox64(pb) || rb1 !== mb) begin
            errors++; $display("FAIL b2b_second: got %h/%h expected %h/%h", rb0, rb1, sbox64(pb) ^ mb, mb);
        end
    endtask

    task automatic test_latency_sweep();
        int acc, ov, vc, g; bit st;
        logic [63:0] r0, r1, i0, i1, p, m;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 0 : 2;
            p = rnd64(); m = rnd64();
            run_pass(g, p ^ m, m, 0, 1'b0, 64'h0, 64'h0, acc, ov, r0, r1, i0, i1, vc, st);
            checks++; if (ov !== 17 + lat_of(g)) begin
                errors++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", lat_of(g), ov, 17 + lat_of(g));
            end
            checks++; if ((r0 ^ r1) !== sbox64(p) || r1 !== m) begin
                errors++; $display("FAIL sweep_result[%0d]: got %h/%h expected %h/%h", lat_of(g), r0, r1, sbox64(p) ^ m, m);
            end
            checks++; if (i0 !== (p ^ m) || i1 !== m || vc !== 16) begin
                errors++; $display("FAIL sweep_issue[%0d]: got %h/%h n=%0d expected %h/%h n=16", lat_of(g), i0, i1, vc, p ^ m, m);
            end
            @(negedge clk);
            @(negedge clk);
`ifdef SCHED_ZEROIZE_EN
            checks++; if (out_sh0[g] !== 64'h0 || out_sh1[g] !== 64'h0 || sb_in_sh0[g] !== 4'h0 || sb_in_sh1[g] !== 4'h0) begin
                errors++; $display("FAIL sweep_zeroized[%0d]: got %h/%h %h/%h expected all 0", lat_of(g),
                                   out_sh0[g], out_sh1[g], sb_in_sh0[g], sb_in_sh1[g]);
            end
`else
            checks++; if (out_sh0[g] !== r0 || out_sh1[g] !== r1 || sb_in_sh0[g] !== (p[63:60] ^ m[63:60]) || sb_in_sh1[g] !== m[63:60]) begin
                errors++; $display("FAIL sweep_retained[%0d]: got %h/%h %h/%h expected %h/%h %h/%h", lat_of(g),
                                   out_sh0[g], out_sh1[g], sb_in_sh0[g], sb_in_sh1[g], r0, r1, p[63:60] ^ m[63:60], m[63:60]);
            end
`endif
            checks++; if (busy[g] !== 1'b0 || in_ready[g] !== 1'b1) begin
                errors++; $display("FAIL sweep_idle[%0d]: got busy=%0d in_ready=%0d expected 0/1", lat_of(g), busy[g], in_ready[g]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
            in_valid[g] = 1'b0; out_ready[g] = 1'b0; in_sh0[g] = '0; in_sh1[g] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_masked();
        test_backpressure();
        test_reset_midpass();
        test_back_to_back();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
